// File: rtl/relu_stage_pkg.sv
// Shared types and helpers for the serial ReLU stage: FSM state encoding and sizing helper.
package relu_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // $clog2 clamped to at least one bit so degenerate sizes still give legal vectors.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_elem.sv
// Single-element ReLU on raw IEEE-754 bits: any set sign bit (incl. -0, -inf, -NaN) yields zero.
module relu_elem #(
    parameter int unsigned S = 32
) (
    input  logic [S-1:0] in,
    output logic [S-1:0] out
);

    assign out = in[S-1] ? '0 : in;

endmodule

// File: rtl/relu_stage.sv
// Serial ReLU over a captured HxW fp32 matrix, one element per clock through a shared relu_elem.
// Optional per-row argmax is enabled by defining RELU_ARGMAX_EN.
module relu_stage
    import relu_stage_pkg::*;
#(
    parameter  int unsigned S  = 32,
    parameter  int unsigned H  = 4,
    parameter  int unsigned W  = 6,
    localparam int unsigned IW = clog2_min1(W)
) (
    input  logic               rst_n,
    input  logic               clk,
    input  logic               start,
    input  logic [H*W*S-1:0]   i,
    output logic [H*W*S-1:0]   o,
    output logic               busy,
    output logic               done,
    output logic [H*IW-1:0]    idx
);

    localparam int unsigned N  = H * W;
    localparam int unsigned KW = $clog2(N + 1);
    localparam int unsigned LW = clog2_min1(N * S);

    state_e             state_q, state_d;
    logic               busy_d, done_d;
    logic               cap_en, step;
    logic [KW-1:0]      k_q;
    logic [N*S-1:0]     cap_q;
    logic [LW-1:0]      elem_lo;
    logic [S-1:0]       relu_y;

    // FSM state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_en  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (k_q == KW'(N - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Element k sits at the k-th slot down from the MSBs
    always_comb begin
        elem_lo = LW'((N - 1 - 32'(k_q)) * S);
    end

    relu_elem #(.S(S)) u_relu_elem (
        .in  (cap_q[elem_lo +: S]),
        .out (relu_y)
    );

    // Capture register, element counter and in-place output slot writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            cap_q <= '0;
            o     <= '0;
        end else if (cap_en) begin
            cap_q <= i;
            k_q   <= '0;
        end else if (step) begin
            o[elem_lo +: S] <= relu_y;
            k_q             <= k_q + KW'(1);
        end
    end

`ifdef RELU_ARGMAX_EN
    localparam int unsigned RW = clog2_min1(H);

    logic [RW-1:0] row_q;
    logic [IW-1:0] col_q;
    logic [S-1:0]  max_q;
    logic [IW-1:0] idx_q [H];

    // Running row max; post-ReLU values are non-negative so unsigned compare orders them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            max_q <= '0;
            for (int r = 0; r < int'(H); r++) idx_q[r] <= '0;
        end else if (cap_en) begin
            row_q <= '0;
            col_q <= '0;
        end else if (step) begin
            if (col_q == IW'(0) || relu_y > max_q) begin
                max_q        <= relu_y;
                idx_q[row_q] <= col_q;
            end
            if (col_q == IW'(W - 1)) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + IW'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(H); g++) begin : g_idx
        assign idx[(H-g)*IW-1 -: IW] = idx_q[g];
    end
`else
    assign idx = '0;
`endif

endmodule

// File: tb/tb_relu_stage.sv
// Self-checking bench for relu_stage: randomized matrices against a spec-level ReLU/argmax model.
module tb_relu_stage;

    localparam int unsigned S  = 32;
    localparam int unsigned H  = 4;
    localparam int unsigned W  = 6;
    localparam int unsigned N  = H * W;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = N * S;

    typedef logic [CW-1:0]   mat_t;
    typedef logic [H*IW-1:0] idx_t;

    logic rst_n, clk, start;
    mat_t i, o;
    logic busy, done;
    idx_t idx;

    int checks   = 0;
    int failures = 0;

    relu_stage #(.S(S), .H(H), .W(W)) dut (
        .rst_n (rst_n),
        .clk   (clk),
        .start (start),
        .i     (i),
        .o     (o),
        .busy  (busy),
        .done  (done),
        .idx   (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [S-1:0] get_el(input mat_t m, input int r, input int c);
        return m[(N - 1 - (r * W + c)) * S +: S];
    endfunction

    function automatic mat_t put_el(input mat_t m, input int r, input int c, input logic [S-1:0] v);
        mat_t t;
        t = m;
        t[(N - 1 - (r * W + c)) * S +: S] = v;
        return t;
    endfunction

    function automatic logic [S-1:0] relu(input logic [S-1:0] v);
        return v[S-1] ? '0 : v;
    endfunction

    function automatic mat_t ref_relu(input mat_t m);
        mat_t t;
        t = m;
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++)
                t = put_el(t, r, c, relu(get_el(m, r, c)));
        return t;
    endfunction

    function automatic idx_t ref_idx(input mat_t m);
        idx_t res;
        res = '0;
`ifdef RELU_ARGMAX_EN
        for (int r = 0; r < int'(H); r++) begin
            int best;
            logic [S-1:0] bv;
            best = 0;
            bv   = relu(get_el(m, r, 0));
            for (int c = 1; c < int'(W); c++) begin
                if (relu(get_el(m, r, c)) > bv) begin
                    bv   = relu(get_el(m, r, c));
                    best = c;
                end
            end
            res[(H - r) * IW - 1 -: IW] = IW'(best);
        end
`endif
        return res;
    endfunction

    function automatic logic [S-1:0] rnd_el();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h4000_0000;
            3:       return 32'h3f80_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic mat_t rnd_mat();
        mat_t t;
        t = '0;
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++)
                t = put_el(t, r, c, rnd_el());
        return t;
    endfunction

    // One pass: done must land after edge 25 exactly once, busy high through RUN and low with done.
    task automatic run_pass(input mat_t m, input bit pre, input int rep_at, input mat_t mr,
                            input bit chain, input mat_t mn);
        int nd, de, bb;
        nd = 0; de = -1; bb = 0;
        if (!pre) begin
            @(negedge clk);
            i = m;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 27; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (de < 0) de = e;
            end
            if (e <= 24 && busy !== 1'b1) bb++;
            if (e == 25) begin
                if (busy !== 1'b0) bb++;
                check("o", o, ref_relu(m));
                check("idx", CW'(idx), CW'(ref_idx(m)));
                if (chain) begin
                    i = mn;
                    start = 1'b1;
                    break;
                end
            end
            if (e == rep_at) begin
                i = mr;
                start = 1'b1;
            end
        end
        check("done_edge", CW'(de), CW'(25));
        check("done_cnt", CW'(nd), CW'(1));
        check("busy", CW'(bb), CW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t m, m2;
        logic [S-1:0] t1 [W];
        logic [S-1:0] t3 [W];
        logic [S-1:0] t4 [W];
        logic [W*S-1:0] row_exp;
        idx_t idx_exp;
        int nd;

        t1 = '{32'h3f8e5eea, 32'hbeb0ce44, 32'h3f1ba995, 32'h3f2418fc, 32'hbf364b07, 32'h3f945f07};
        t3 = '{32'h80000000, 32'hff800000, 32'hffc00000, 32'h7fc00000, 32'h7f800000, 32'h00000001};
        t4 = '{32'h40000000, 32'h3f800000, 32'h40000000, 32'h0, 32'h0, 32'h0};

        rst_n = 1'b0; start = 1'b0; i = '0;
        repeat (2) @(negedge clk);
        check("rst_o", o, '0);
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        check("rst_idx", CW'(idx), CW'(0));
        rst_n = 1'b1;

        // Mixed signs in row 0
        m = rnd_mat();
        for (int c = 0; c < int'(W); c++) m = put_el(m, 0, c, t1[c]);
        run_pass(m, 1'b0, -1, '0, 1'b0, '0);
        row_exp = {32'h3f8e5eea, 32'h0, 32'h3f1ba995, 32'h3f2418fc, 32'h0, 32'h3f945f07};
        check("t1_row0", CW'(o[CW-1 -: W*S]), CW'(row_exp));
`ifdef RELU_ARGMAX_EN
        idx_exp = idx;
        check("t1_idx0", CW'(idx_exp[H*IW-1 -: IW]), CW'(5));
`endif

        // IEEE specials in row 0, tie/zero row 1, all-negative row 2
        m = rnd_mat();
        for (int c = 0; c < int'(W); c++) begin
            m = put_el(m, 0, c, t3[c]);
            m = put_el(m, 1, c, t4[c]);
            m = put_el(m, 2, c, 32'h8000_0000 | ($urandom & 32'h7fff_ffff));
        end
        run_pass(m, 1'b0, -1, '0, 1'b0, '0);
        row_exp = {32'h0, 32'h0, 32'h0, 32'h7fc00000, 32'h7f800000, 32'h00000001};
        check("t3_row0", CW'(o[CW-1 -: W*S]), CW'(row_exp));
        check("t4_row2", CW'(o[CW-2*W*S-1 -: W*S]), '0);
`ifdef RELU_ARGMAX_EN
        idx_exp = idx;
        check("t3_idx0", CW'(idx_exp[H*IW-1 -: IW]), CW'(3));
        check("t4_idx1", CW'(idx_exp[(H-1)*IW-1 -: IW]), CW'(0));
        check("t4_idx2", CW'(idx_exp[(H-2)*IW-1 -: IW]), CW'(0));
`endif

        // start re-pulsed mid-pass with different data is ignored
        m  = rnd_mat();
        m2 = ~m;
        run_pass(m, 1'b0, 10, m2, 1'b0, '0);

        // Back-to-back passes: start accepted in the IDLE cycle right after done
        m  = rnd_mat();
        m2 = rnd_mat();
        run_pass(m, 1'b0, -1, '0, 1'b1, m2);
        run_pass(m2, 1'b1, -1, '0, 1'b0, '0);

        // Reset mid-pass aborts with no done pulse
        m = rnd_mat();
        @(negedge clk);
        i = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        rst_n = 1'b0;
        #1;
        check("abort_o", o, '0);
        check("abort_busy", CW'(busy), CW'(0));
        check("abort_done", CW'(done), CW'(0));
        check("abort_idx", CW'(idx), CW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("abort_nodone", CW'(nd), CW'(0));
        m = rnd_mat();
        run_pass(m, 1'b0, -1, '0, 1'b0, '0);

        // Random passes
        for (int p = 0; p < 5; p++) begin
            m = rnd_mat();
            run_pass(m, 1'b0, -1, '0, 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
